// File: rtl/avgpool_scheduler_pkg.sv
// Shared types and constants for the 2x2 average-pool scheduler.
package avgpool_scheduler_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRowTop,
    StRowBot,
    StIssue,
    StHold,
    StDone
  } sched_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/avgpool_line_buffer.sv
// One-row pixel store: single write port, two read ports with registered addresses.
module avgpool_line_buffer
  import avgpool_scheduler_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]  raddr_a_i,
  input  logic [AddrW-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [AddrW-1:0]  raddr_a_q;
  logic [AddrW-1:0]  raddr_b_q;

  // Contents are always rewritten by a top row before being read, so no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raddr_a_q <= '0;
      raddr_b_q <= '0;
    end else begin
      raddr_a_q <= raddr_a_i;
      raddr_b_q <= raddr_b_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_q];
  assign rdata_b_o = mem_q[raddr_b_q];

endmodule

// File: rtl/avgpool_scheduler.sv
// Streams a raster frame, issues 2x2 windows to an external averaging datapath and returns
// the pooled results. Optional statistics outputs are enabled by AVGPOOL_SCHED_STATS_EN.
module avgpool_scheduler
  import avgpool_scheduler_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = 8,
  parameter int unsigned ROW_COUNT = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  output logic               Busy,
  input  logic               In_Valid,
  input  logic [DATA_W-1:0]  In_Data,
  output logic               In_Ready,
  output logic [DATA_W-1:0]  Pool_In_1,
  output logic [DATA_W-1:0]  Pool_In_2,
  output logic [DATA_W-1:0]  Pool_In_3,
  output logic [DATA_W-1:0]  Pool_In_4,
  input  logic [DATA_W-1:0]  Pool_Out,
  output logic               Out_Valid,
  output logic [DATA_W-1:0]  Out_Data,
  input  logic               Out_Ready,
  output logic               Frame_Done
`ifdef AVGPOOL_SCHED_STATS_EN
  ,
  output logic [COUNT_W-1:0] Window_Count,
  output logic [COUNT_W-1:0] Stall_Count
`endif
);

  localparam int unsigned ColW     = $clog2(ROW_WIDTH);
  localparam int unsigned PairCnt  = ROW_COUNT / 2;
  localparam int unsigned PairW    = (PairCnt > 1) ? $clog2(PairCnt) : 1;
  localparam logic [ColW-1:0]  ColLast  = ColW'(ROW_WIDTH - 1);
  localparam logic [PairW-1:0] PairLast = PairW'(PairCnt - 1);

  sched_state_e      state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [PairW-1:0]  pair_q, pair_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] pool_tl_q, pool_tr_q, pool_bl_q, pool_br_q;

  logic              in_xfer;
  logic              load_win;
  logic              lb_we;
  logic [ColW-1:0]   lb_raddr_a, lb_raddr_b;
  logic [DATA_W-1:0] lb_rdata_a, lb_rdata_b;

  assign In_Ready   = (state_q == StRowTop) || (state_q == StRowBot);
  assign Busy       = (state_q != StIdle);
  assign Out_Valid  = (state_q == StHold);
  assign Frame_Done = (state_q == StDone);
  assign Out_Data   = Pool_Out;
  assign in_xfer    = In_Valid && In_Ready;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pair_d   = pair_q;
    left_d   = left_q;
    load_win = 1'b0;
    lb_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRowTop;
        end
      end
      StRowTop: begin
        if (in_xfer) begin
          lb_we = 1'b1;
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = StRowBot;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StRowBot: begin
        if (in_xfer) begin
          if (!col_q[0]) begin
            left_d = In_Data;
          end else begin
            load_win = 1'b1;
            state_d  = StIssue;
          end
          col_d = (col_q == ColLast) ? '0 : col_q + ColW'(1);
        end
      end
      StIssue: begin
        state_d = StHold;
      end
      StHold: begin
        // col has already advanced past the window, so zero means the row pair is finished.
        if (Out_Ready) begin
          if (col_q != '0) begin
            state_d = StRowBot;
          end else if (pair_q == PairLast) begin
            pair_d  = '0;
            state_d = StDone;
          end else begin
            pair_d  = pair_q + PairW'(1);
            state_d = StRowTop;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      col_q     <= '0;
      pair_q    <= '0;
      left_q    <= '0;
      pool_tl_q <= '0;
      pool_tr_q <= '0;
      pool_bl_q <= '0;
      pool_br_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pair_q  <= pair_d;
      left_q  <= left_d;
      if (load_win) begin
        pool_tl_q <= lb_rdata_a;
        pool_tr_q <= lb_rdata_b;
        pool_bl_q <= left_q;
        pool_br_q <= In_Data;
      end
    end
  end

  // Read addresses follow the column pair the next bottom-row pixel belongs to, so the
  // top-row pair is already presented when the odd-column pixel arrives.
  assign lb_raddr_a = col_d & ~ColW'(1);
  assign lb_raddr_b = col_d | ColW'(1);

  avgpool_line_buffer #(
    .Depth (ROW_WIDTH),
    .AddrW (ColW)
  ) u_line_buffer (
    .clk_i     (Clock),
    .rst_ni    (Reset_n),
    .we_i      (lb_we),
    .waddr_i   (col_q),
    .wdata_i   (In_Data),
    .raddr_a_i (lb_raddr_a),
    .raddr_b_i (lb_raddr_b),
    .rdata_a_o (lb_rdata_a),
    .rdata_b_o (lb_rdata_b)
  );

  assign Pool_In_1 = pool_tl_q;
  assign Pool_In_2 = pool_tr_q;
  assign Pool_In_3 = pool_bl_q;
  assign Pool_In_4 = pool_br_q;

`ifdef AVGPOOL_SCHED_STATS_EN
  logic [COUNT_W-1:0] win_cnt_q;
  logic [COUNT_W-1:0] stall_cnt_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      win_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && Start) begin
      win_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == StHold) begin
      if (Out_Ready) begin
        win_cnt_q <= sat_inc(win_cnt_q);
      end else begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign Window_Count = win_cnt_q;
  assign Stall_Count  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_avgpool_scheduler.sv
// Randomized self-checking bench for avgpool_scheduler (4x4 main instance, 2x2 side instance).
module tb_avgpool_scheduler;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } win_t;

  logic        Clock    = 1'b0;
  logic        Reset_n  = 1'b0;
  logic        Start    = 1'b0;
  logic        In_Valid = 1'b0;
  logic [31:0] In_Data  = '0;
  logic        Out_Ready = 1'b1;
  logic [31:0] Pool_Out = '0;
  logic        Busy, In_Ready, Out_Valid, Frame_Done;
  logic [31:0] Pool_In_1, Pool_In_2, Pool_In_3, Pool_In_4, Out_Data;

  logic        s_Start    = 1'b0;
  logic        s_In_Valid = 1'b0;
  logic [31:0] s_In_Data  = '0;
  logic        s_Out_Ready = 1'b1;
  logic [31:0] s_Pool_Out = '0;
  logic        s_Busy, s_In_Ready, s_Out_Valid, s_Frame_Done;
  logic [31:0] s_Pool_In_1, s_Pool_In_2, s_Pool_In_3, s_Pool_In_4, s_Out_Data;

`ifdef AVGPOOL_SCHED_STATS_EN
  logic [15:0] Window_Count, Stall_Count, s_Window_Count, s_Stall_Count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame_px [W*H];
  win_t        exp_q [$];
  logic [31:0] obs_q [$];
  bit          chk_en = 0;
  bit          model_busy = 0;
  bit          done_due = 0;
  bit          lat_pend = 0;
  bit          hold_low = 0;
  int          lat_cnt = 0;
  int          pix_idx = 0;
  int          rdy_mode = 0;
  int          stall_model = 0;

  avgpool_scheduler #(
    .ROW_WIDTH (W),
    .ROW_COUNT (H)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Busy         (Busy),
    .In_Valid     (In_Valid),
    .In_Data      (In_Data),
    .In_Ready     (In_Ready),
    .Pool_In_1    (Pool_In_1),
    .Pool_In_2    (Pool_In_2),
    .Pool_In_3    (Pool_In_3),
    .Pool_In_4    (Pool_In_4),
    .Pool_Out     (Pool_Out),
    .Out_Valid    (Out_Valid),
    .Out_Data     (Out_Data),
    .Out_Ready    (Out_Ready),
    .Frame_Done   (Frame_Done)
`ifdef AVGPOOL_SCHED_STATS_EN
    ,
    .Window_Count (Window_Count),
    .Stall_Count  (Stall_Count)
`endif
  );

  avgpool_scheduler #(
    .ROW_WIDTH (2),
    .ROW_COUNT (2)
  ) dut_small (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (s_Start),
    .Busy         (s_Busy),
    .In_Valid     (s_In_Valid),
    .In_Data      (s_In_Data),
    .In_Ready     (s_In_Ready),
    .Pool_In_1    (s_Pool_In_1),
    .Pool_In_2    (s_Pool_In_2),
    .Pool_In_3    (s_Pool_In_3),
    .Pool_In_4    (s_Pool_In_4),
    .Pool_Out     (s_Pool_Out),
    .Out_Valid    (s_Out_Valid),
    .Out_Data     (s_Out_Data),
    .Out_Ready    (s_Out_Ready),
    .Frame_Done   (s_Frame_Done)
`ifdef AVGPOOL_SCHED_STATS_EN
    ,
    .Window_Count (s_Window_Count),
    .Stall_Count  (s_Stall_Count)
`endif
  );

  function automatic logic [31:0] avg4(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [33:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[33:2];
  endfunction

  // External averaging datapath: one registered stage.
  always_ff @(posedge Clock) begin
    Pool_Out   <= avg4(Pool_In_1, Pool_In_2, Pool_In_3, Pool_In_4);
    s_Pool_Out <= avg4(s_Pool_In_1, s_Pool_In_2, s_Pool_In_3, s_Pool_In_4);
  end

  initial forever #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame-level model: windows derived from the pixel array on an accepted Start.
  task automatic monitor_step();
    win_t w;
    bit   exp_done;
    if (!Reset_n) begin
      exp_q.delete();
      model_busy = 0;
      done_due   = 0;
      lat_pend   = 0;
      pix_idx    = 0;
      return;
    end
    if (!chk_en) return;
    chk("busy", 32'(Busy), 32'(model_busy));
    exp_done = done_due;
    done_due = 0;
    chk("frame_done", 32'(Frame_Done), 32'(exp_done));
    if (Start && !model_busy) begin
      model_busy  = 1;
      pix_idx     = 0;
      stall_model = 0;
      obs_q.delete();
      exp_q.delete();
      for (int r = 0; r < H / 2; r++) begin
        for (int c = 0; c < W / 2; c++) begin
          w.a = frame_px[(2 * r) * W + 2 * c];
          w.b = frame_px[(2 * r) * W + 2 * c + 1];
          w.c = frame_px[(2 * r + 1) * W + 2 * c];
          w.d = frame_px[(2 * r + 1) * W + 2 * c + 1];
          exp_q.push_back(w);
        end
      end
    end else if (exp_done) begin
      model_busy = 0;
    end
    if (lat_pend) begin
      lat_cnt++;
      if (Out_Valid || lat_cnt >= 2) begin
        chk("br_pixel_to_out_valid", Out_Valid ? 32'(lat_cnt) : 32'd99, 32'd2);
        lat_pend = 0;
      end
    end
    if (In_Valid && In_Ready) begin
      if (((pix_idx / W) % 2 == 1) && ((pix_idx % W) % 2 == 1)) begin
        lat_pend = 1;
        lat_cnt  = 0;
      end
      pix_idx++;
    end
    if (Out_Valid) begin
      chk("in_ready_while_holding", 32'(In_Ready), 32'd0);
      chk("window_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q[0];
        chk("pool_in_1", Pool_In_1, w.a);
        chk("pool_in_2", Pool_In_2, w.b);
        chk("pool_in_3", Pool_In_3, w.c);
        chk("pool_in_4", Pool_In_4, w.d);
        chk("out_data", Out_Data, avg4(w.a, w.b, w.c, w.d));
      end
      if (Out_Ready) begin
        obs_q.push_back(Out_Data);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1;
        end
      end else begin
        stall_model++;
      end
    end
  endtask

  task automatic start_frame();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct);
    int i = 0;
    int cyc = 0;
    logic xfer;
    while (i < n && cyc < 3000) begin
      if (int'($urandom_range(99)) >= gap_pct) begin
        In_Valid = 1'b1;
        In_Data  = frame_px[i];
      end else begin
        In_Valid = 1'b0;
        In_Data  = $urandom;
      end
      @(negedge Clock);
      xfer = In_Valid && In_Ready;
      @(posedge Clock); #1;
      if (xfer) i++;
      cyc++;
    end
    In_Valid = 1'b0;
    chk("pixels_fed", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge Clock);
      if (Frame_Done) seen = 1;
    end
    chk("frame_done_reached", 32'(seen), 32'd1);
    @(posedge Clock); #1;
  endtask

  task automatic check_obs(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk("obs_count", 32'(obs_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("obs_%0d", k), (k < obs_q.size()) ? obs_q[k] : 32'hDEAD_BEEF, e[k]);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clock);
        monitor_step();
      end
      forever begin
        @(posedge Clock); #1;
        if (hold_low) Out_Ready = 1'b0;
        else if (rdy_mode == 1) Out_Ready = 1'($urandom_range(1));
        else Out_Ready = 1'b1;
      end
      begin : main_seq
        for (int i = 0; i < W * H; i++) frame_px[i] = 32'(i);
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd0);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_frame_done", 32'(Frame_Done), 32'd0);
        chk("rst_pool_in_1", Pool_In_1, 32'd0);
        chk("rst_pool_in_4", Pool_In_4, 32'd0);
        chk("rst_out_data_follows", Out_Data, Pool_Out);
        Reset_n = 1'b1;
        chk_en  = 1;
        @(posedge Clock); #1;

        // Ramp frame, no backpressure.
        start_frame();
        feed(16, 0);
        wait_done();
        check_obs(2, 4, 10, 12);
`ifdef AVGPOOL_SCHED_STATS_EN
        chk("win_count_ramp", 32'(Window_Count), 32'd4);
        chk("stall_count_ramp", 32'(Stall_Count), 32'd0);
`endif

        // Five stalled cycles on the first window.
        hold_low = 1;
        start_frame();
        fork
          feed(16, 0);
          begin
            int low = 0;
            int cyc = 0;
            while (low < 5 && cyc < 1000) begin
              @(negedge Clock);
              cyc++;
              if (Out_Valid) begin
                low++;
                chk("stall_out_data", Out_Data, 32'd2);
                chk("stall_in_ready", 32'(In_Ready), 32'd0);
              end
            end
            chk("stall_cycles_seen", 32'(low), 32'd5);
            hold_low = 0;
          end
        join
        wait_done();
        check_obs(2, 4, 10, 12);
`ifdef AVGPOOL_SCHED_STATS_EN
        chk("stall_count_five", 32'(Stall_Count), 32'd5);
        chk("win_count_stall", 32'(Window_Count), 32'd4);
`endif

        // Start while busy in the bottom row must be ignored.
        start_frame();
        fork
          feed(16, 0);
          begin
            int cyc = 0;
            while (pix_idx < 5 && cyc < 200) begin
              @(negedge Clock);
              cyc++;
            end
            @(posedge Clock); #1;
            Start = 1'b1;
            chk("busy_at_restart", 32'(Busy), 32'd1);
            @(posedge Clock); #1;
            Start = 1'b0;
          end
        join
        wait_done();
        check_obs(2, 4, 10, 12);
        repeat (5) @(posedge Clock);
        #1;

        // Random frames with input gaps and random backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 6; f++) begin
          for (int i = 0; i < W * H; i++) frame_px[i] = $urandom;
          start_frame();
          feed(16, 30);
          wait_done();
`ifdef AVGPOOL_SCHED_STATS_EN
          chk("win_count_rand", 32'(Window_Count), 32'd4);
          chk("stall_count_rand", 32'(Stall_Count), 32'(stall_model));
`endif
        end
        rdy_mode = 0;

        // Reset during the second row pair, then a fresh constant frame.
        for (int i = 0; i < W * H; i++) frame_px[i] = 32'(i);
        start_frame();
        feed(10, 0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_in_ready", 32'(In_Ready), 32'd0);
        chk("midrst_out_valid", 32'(Out_Valid), 32'd0);
        chk("midrst_frame_done", 32'(Frame_Done), 32'd0);
        chk("midrst_pool_in_1", Pool_In_1, 32'd0);
        chk("midrst_pool_in_2", Pool_In_2, 32'd0);
        chk("midrst_pool_in_3", Pool_In_3, 32'd0);
        chk("midrst_pool_in_4", Pool_In_4, 32'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        for (int i = 0; i < W * H; i++) frame_px[i] = 32'd8;
        start_frame();
        feed(16, 20);
        wait_done();
        check_obs(8, 8, 8, 8);
`ifdef AVGPOOL_SCHED_STATS_EN
        chk("win_count_after_rst", 32'(Window_Count), 32'd4);
`endif

        // Minimal 2x2 frame on the side instance.
        begin
          logic [31:0] px4 [4];
          int k = 0;
          int cyc = 0;
          logic xfer;
          px4[0] = 32'd4; px4[1] = 32'd8; px4[2] = 32'd12; px4[3] = 32'd16;
          s_Start = 1'b1;
          @(posedge Clock); #1;
          s_Start = 1'b0;
          while (k < 4 && cyc < 100) begin
            s_In_Valid = 1'b1;
            s_In_Data  = px4[k];
            @(negedge Clock);
            xfer = s_In_Valid && s_In_Ready;
            @(posedge Clock); #1;
            if (xfer) k++;
            cyc++;
          end
          s_In_Valid = 1'b0;
          chk("small_pixels_fed", 32'(k), 32'd4);
          @(negedge Clock);
          chk("small_valid_cycle1", 32'(s_Out_Valid), 32'd0);
          @(negedge Clock);
          chk("small_valid_cycle2", 32'(s_Out_Valid), 32'd1);
          chk("small_out_data", s_Out_Data, 32'd10);
          chk("small_pool_in_3", s_Pool_In_3, 32'd12);
          @(negedge Clock);
          chk("small_frame_done", 32'(s_Frame_Done), 32'd1);
          @(negedge Clock);
          chk("small_frame_done_drop", 32'(s_Frame_Done), 32'd0);
          chk("small_idle", 32'(s_Busy), 32'd0);
`ifdef AVGPOOL_SCHED_STATS_EN
          chk("small_win_count", 32'(s_Window_Count), 32'd1);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule

// File: doc/avgpool_scheduler.md
AVGPOOL_SCHEDULER -- requirements
Module: avgpool_scheduler

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 8: pixels per input row; even, >= 2.
REQ-002 SHALL have parameter ROW_COUNT, default 8: rows per frame; even, >= 2.
REQ-003 SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1 bit: one-cycle pulse that begins a frame; ignored unless IDLE.
REQ-006 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have ports In_Valid (input, 1), In_Data (input, 32) and In_Ready (output, 1): raster-order pixel stream; a pixel transfers when In_Valid and In_Ready are both high.
REQ-008 SHALL have ports Pool_In_1..Pool_In_4, output, 32 bits each: registered 2x2 window to the averaging datapath in order top-left, top-right, bottom-left, bottom-right.
REQ-009 SHALL have port Pool_Out, input, 32 bits: datapath result, registered one cycle after Pool_In_* change.
REQ-010 SHALL have ports Out_Valid (output, 1), Out_Data (output, 32) and Out_Ready (input, 1): pooled result stream.
REQ-011 SHALL have port Frame_Done, output, 1 bit: one-cycle pulse when the last window of a frame is accepted downstream.

Function
REQ-012 SHALL implement FSM states IDLE, ROW_TOP, ROW_BOT, ISSUE, HOLD, DONE.
REQ-013 IDLE->ROW_TOP on Start; In_Ready low in IDLE and DONE.
REQ-014 ROW_TOP: each accepted pixel SHALL be written to line-buffer[col]; after col = ROW_WIDTH-1, col wraps to 0 and state -> ROW_BOT.
REQ-015 ROW_BOT, even col: accepted pixel SHALL be held in a left register. Odd col: Pool_In_1..4 SHALL be loaded with lb[col-1], lb[col], left, pixel, and state -> ISSUE.
REQ-016 ISSUE: one wait cycle for datapath latency; In_Ready low; next state HOLD.
REQ-017 HOLD: Out_Valid high and Out_Data = Pool_Out. Pool_In_* SHALL stay unchanged so Pool_Out stays stable.
REQ-018 HOLD exit occurs on Out_Ready and goes to:
- ROW_BOT if col != 0;
- ROW_TOP if col == 0 and row pair not last;
- DONE if col == 0 and row pair is last.
REQ-019 In_Ready SHALL be high only in ROW_TOP and ROW_BOT, so at most one window is in flight and no input is lost under backpressure.
REQ-020 DONE SHALL pulse Frame_Done for one cycle and then go to IDLE.
REQ-021 Column and row-pair counters SHALL wrap exactly at ROW_WIDTH-1 and ROW_COUNT/2-1.
REQ-022 Start asserted while Busy SHALL be ignored with no state effect.
REQ-023 Latency from the accepted bottom-right pixel to Out_Valid high SHALL be exactly 2 cycles.
REQ-024 The scheduler SHALL perform no arithmetic on pixel data; widths SHALL pass through unchanged.

Reset
REQ-025 Reset_n low SHALL immediately force:
- state IDLE;
- col, row-pair, left register and Pool_In_* = 0;
- Busy, In_Ready, Out_Valid, Frame_Done = 0;
- Out_Data reflects Pool_Out.
REQ-026 Reset mid-frame SHALL abandon the frame; line-buffer contents need not be cleared, since ROW_TOP rewrites them before use.

Configuration
REQ-027 With macro AVGPOOL_SCHED_STATS_EN defined, the block SHALL add two outputs:
- Window_Count[15:0]: windows accepted downstream;
- Stall_Count[15:0]: HOLD cycles with Out_Ready low.
Both cleared by reset and on Start, and saturating at 16'hFFFF.
REQ-028 Without AVGPOOL_SCHED_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, DATA_W = 32, and COUNT_W = 16.
REQ-030 The line buffer SHALL be sub-module avgpool_line_buffer: ROW_WIDTH x 32, one write port, two registered-address read ports.

Verification
REQ-031 4x4 frame, pixels 0..15, Out_Ready=1 -> Out_Data sequence 2, 4, 10, 12; Frame_Done pulses once after 12.
REQ-032 Same frame with Out_Ready low for 5 cycles at first window -> Out_Data held at 2 and In_Ready low throughout; sequence unchanged; Stall_Count=5 when STATS_EN.
REQ-033 Start pulse while Busy in ROW_BOT -> no state change; frame output unchanged.
REQ-034 Reset_n low during second row pair of a 4x4 frame, then new Start with all pixels 8 -> four outputs of 8, no stale values.
REQ-035 ROW_WIDTH=2, ROW_COUNT=2, pixels 4, 8, 12, 16 -> single Out_Data 10 at exactly 2 cycles after the 4th pixel; Window_Count=1.
